// File: rtl/linear_interp.sv
// linear_interp: paces FIFO reads at 1/N of clk and emits a linearly interpolated sample each clock.
module linear_interp #(
  parameter int DATA_WIDTH  = 12,
  parameter int INTERP_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] inter_data,
  output logic                  out_valid,
  output logic                  underrun
);
  localparam int W = DATA_WIDTH;
  localparam int L = INTERP_LOG2;
  localparam logic [1:0] PRIME = 2'd0, RUN = 2'd1, STALL = 2'd2;
  logic [W-1:0] x0_q, x0_d, x1_q, x1_d, nxt_q, nxt_d, inter_q, inter_d, y;
  logic nxt_valid_q, nxt_valid_d, rd_pend_q, cnt_q, cnt_d;
  logic out_valid_q, out_valid_d, underrun_q, underrun_d;
  logic [L-1:0] p_q, p_d;
  logic [1:0] state_q, state_d;
  logic [W:0] d;
  logic signed [W+L:0] prod, sh;
  logic [L:0] unused_hi;
  logic run, last, load, starve;
  assign rd_en = ena & ~fifo_empty & ~rd_pend_q & ~nxt_valid_q & ~rst;
  assign run = state_q == RUN;
  assign last = &p_q;
  assign load = ena && nxt_valid_q && (state_q != RUN || last);
  assign starve = run && ena && last && !nxt_valid_q;
  // y stays between x0 and x1, so the dropped upper bits carry no information
  assign d = {x1_q[W-1], x1_q} - {x0_q[W-1], x0_q};
  assign prod = {{L{d[W]}}, d} * {{(W+1){1'b0}}, p_q};
  assign sh = prod >>> L;
  assign {unused_hi, y} = {{(L+1){x0_q[W-1]}}, x0_q} + sh;
  assign inter_data = inter_q;
  assign out_valid = out_valid_q;
  assign underrun = underrun_q;
  always_comb begin
    x0_d = load ? x1_q : x0_q;
    x1_d = load ? nxt_q : x1_q;
    nxt_d = rd_pend_q ? dataIn : nxt_q;
    nxt_valid_d = rd_pend_q | (nxt_valid_q & ~load);
    cnt_d = (state_q == PRIME && load) ? ~cnt_q : cnt_q;
    p_d = load ? '0 : (run && ena && !last) ? p_q + L'(1) : p_q;
    state_d = (load && (state_q == STALL || cnt_q)) ? RUN : starve ? STALL : state_q;
    underrun_d = starve;
    out_valid_d = run & ena;
    inter_d = (run && ena) ? y : inter_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q <= '0;
      x1_q <= '0;
      nxt_q <= '0;
      nxt_valid_q <= 1'b0;
      rd_pend_q <= 1'b0;
      cnt_q <= 1'b0;
      p_q <= '0;
      state_q <= PRIME;
      inter_q <= '0;
      out_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      x0_q <= x0_d;
      x1_q <= x1_d;
      nxt_q <= nxt_d;
      nxt_valid_q <= nxt_valid_d;
      rd_pend_q <= rd_en;
      cnt_q <= cnt_d;
      p_q <= p_d;
      state_q <= state_d;
      inter_q <= inter_d;
      out_valid_q <= out_valid_d;
      underrun_q <= underrun_d;
    end
  end
endmodule

// File: tb/tb_linear_interp.sv
// tb_linear_interp: table vectors, hand-written corner sequences and a randomized stream check.
module tb_linear_interp;
  localparam int W = 12, L = 2, N = 4;
  logic clk = 1'b0, rst = 1'b0, ena = 1'b1, fifo_empty = 1'b1;
  logic [W-1:0] dataIn = '0, inter_data;
  logic rd_en, out_valid, underrun;
  int checks = 0, errors = 0, cyc = 0, pops = 0, prev = 0;
  bit have_prev = 0;
  int q[$];
  int exp_q[$];
  typedef struct packed { int a; int b; int e0; int e1; int e2; int e3; } vec_t;
  vec_t vt[7];
  always #5 clk = ~clk;
  linear_interp #(.DATA_WIDTH(W), .INTERP_LOG2(L)) dut (
    .clk(clk), .rst(rst), .ena(ena), .fifo_empty(fifo_empty), .dataIn(dataIn),
    .rd_en(rd_en), .inter_data(inter_data), .out_valid(out_valid), .underrun(underrun)
  );
  function automatic int sx(logic [W-1:0] v);
    return int'($signed(v));
  endfunction
  function automatic int fl_div(int t);
    return (t >= 0) ? t / N : -((-t + N - 1) / N);
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic push(int v);
    q.push_back(v);
    fifo_empty = 1'b0;
  endtask
  task automatic rpush(int v);
    push(v);
    if (have_prev) for (int p = 0; p < N; p++) exp_q.push_back(prev + fl_div((v - prev) * p));
    prev = v;
    have_prev = 1;
  endtask
  // FIFO model: a read strobed at an edge presents its word just after that edge
  task automatic tick();
    logic r;
    #1;
    r = rd_en;
    if (r) chk("rd_en_on_empty", int'(fifo_empty), 0);
    @(posedge clk);
    #1;
    if (r && q.size() > 0) begin
      dataIn = W'(q.pop_front());
      pops++;
    end
    fifo_empty = (q.size() == 0);
    cyc++;
    #1;
  endtask
  task automatic reset_on();
    rst = 1'b1;
    #1;
    chk("rst_inter_data", sx(inter_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    q.delete();
    fifo_empty = 1'b1;
    dataIn = '0;
  endtask
  task automatic reset_off();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    pops = 0;
    #1;
  endtask
  task automatic startup_check(int first);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      chk("startup_rd_en", int'(rd_en), int'(c == 0 || c == 3 || c == 6));
      chk("startup_out_valid", int'(out_valid), int'(c == 7));
    end
    chk("startup_first", sx(inter_data), first);
  endtask
  initial begin
    int ramp[12];
    int e[5];
    ramp = '{0, 100, 200, 300, 400, 200, 0, -200, -400, -275, -150, -25};
    vt[0] = '{0, 400, 0, 100, 200, 300};
    vt[1] = '{400, -400, 400, 200, 0, -200};
    vt[2] = '{0, -1, 0, -1, -1, -1};
    vt[3] = '{-2048, 2047, -2048, -1025, -1, 1023};
    vt[4] = '{2047, -2048, 2047, 1023, -1, -1025};
    vt[5] = '{5, 6, 5, 5, 5, 5};
    vt[6] = '{-7, -3, -7, -6, -5, -4};
    #2;
    for (int i = 0; i < 7; i++) begin
      reset_on();
      push(vt[i].a); push(vt[i].b); push(vt[i].b);
      reset_off();
      startup_check(vt[i].a);
      e = '{vt[i].e0, vt[i].e1, vt[i].e2, vt[i].e3, vt[i].b};
      for (int k = 0; k < 5; k++) begin
        if (k > 0) tick();
        chk("vec_value", sx(inter_data), e[k]);
        chk("vec_out_valid", int'(out_valid), 1);
      end
    end
    // ramp, underrun on starvation, then refill
    reset_on();
    push(0); push(400); push(-400); push(100);
    reset_off();
    startup_check(0);
    for (int c = 7; c <= 31; c++) begin
      if (c > 7) tick();
      if (c <= 18) begin
        chk("ramp_value", sx(inter_data), ramp[c-7]);
        chk("ramp_out_valid", int'(out_valid), 1);
      end else if (c <= 27) begin
        chk("stall_hold", sx(inter_data), -25);
        chk("stall_out_valid", int'(out_valid), 0);
      end else begin
        chk("refill_value", sx(inter_data), 100 + 50 * (c - 28));
        chk("refill_out_valid", int'(out_valid), 1);
      end
      chk("underrun", int'(underrun), int'(c == 18 || c == 31));
      if (c == 10 || c == 14) chk("ramp_rd_en", int'(rd_en), int'(c == 10));
      if (c == 24) begin
        push(300);
        #1;
        chk("refill_rd_en", int'(rd_en), 1);
      end
    end
    // enable gap right after a read strobe
    reset_on();
    push(0); push(400); push(800); push(1200);
    reset_off();
    startup_check(0);
    for (int c = 7; c <= 16; c++) begin
      if (c > 7) tick();
      ena = !(c >= 7 && c <= 11);
      #1;
      chk("gap_value", sx(inter_data), (c <= 12) ? 0 : (c - 12) * 100);
      chk("gap_out_valid", int'(out_valid), int'(c == 7 || c >= 13));
      chk("gap_rd_en", int'(rd_en), int'(c == 15));
      if (c == 12) chk("gap_reads", pops, 3);
    end
    // reset asserted at phase 2
    reset_on();
    push(0); push(400); push(-400); push(100);
    reset_off();
    startup_check(0);
    tick();
    chk("pre_reset_value", sx(inter_data), 100);
    reset_on();
    push(0); push(400); push(-400); push(100);
    reset_off();
    startup_check(0);
    tick();
    chk("post_reset_value", sx(inter_data), 100);
    // randomized stream: every live output must be the next interpolated value
    reset_on();
    reset_off();
    have_prev = 0;
    exp_q.delete();
    for (int i = 0; i < 3000; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      if (q.size() < 3 && $urandom_range(0, ((i / 500) % 2 == 1) ? 7 : 1) == 0)
        rpush(int'($urandom_range(0, 4095)) - 2048);
      #1;
      if (out_valid) chk("rand_value", sx(inter_data), exp_q.size() > 0 ? exp_q.pop_front() : 99999);
      tick();
    end
    ena = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) chk("drain_value", sx(inter_data), exp_q.size() > 0 ? exp_q.pop_front() : 99999);
      tick();
    end
    chk("rand_leftover", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
